// File: rtl/mc_sequencer_if.sv
// Memory handshake bundle between the sequencer and the instruction/data memories.
interface mc_sequencer_if;
  logic imem_req_o;
  logic imem_ready_i;
  logic dmem_req_o;
  logic dmem_we_o;
  logic dmem_ready_i;

  modport master (
    output imem_req_o, dmem_req_o, dmem_we_o,
    input  imem_ready_i, dmem_ready_i
  );

  modport slave (
    input  imem_req_o, dmem_req_o, dmem_we_o,
    output imem_ready_i, dmem_ready_i
  );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback with
// handshake timeouts, a sticky trap state and a retired-instruction counter.
//
// state  | meaning
// FETCH  | request instruction, latch IR when imem ready
// DECODE | check opcode legality
// EXEC   | resolve branches, route loads/stores to MEM
// MEM    | data access until dmem ready
// WB     | register write and PC update
// TRAP   | absorbing fault, left only by reset
module mc_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [6:0]       opcode_i,
  input  logic             br_taken_i,
  mc_sequencer_if.master   mem,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             pc_sel_o,
  output logic             rd_wren_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

  // Counter only needs to reach TIMEOUT-1: the terminal cycle itself decides.
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit          TO_EN  = (TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_TC = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        cause;
  logic [CNT_W-1:0]  retired;

  logic is_load, is_store, is_branch, is_jump, is_legal;
  logic wait_tc;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rd_wren, retire;

  always_comb begin
    is_load   = (opcode_i == OP_LOAD);
    is_store  = (opcode_i == OP_STORE);
    is_branch = (opcode_i == OP_BRANCH);
    is_jump   = (opcode_i == OP_JAL) || (opcode_i == OP_JALR);
    is_legal  = is_load || is_store || is_branch || is_jump ||
                (opcode_i == OP_IMM) || (opcode_i == OP_REG) ||
                (opcode_i == OP_LUI) || (opcode_i == OP_AUIPC);
  end

  assign wait_tc = TO_EN && (wait_cnt == WAIT_TC);

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    rd_wren  = 1'b0;
    retire   = 1'b0;
    if (!rst_i) begin
      case (state)
        S_FETCH: begin
          imem_req = en_i;
          ir_we    = en_i && mem.imem_ready_i;
        end
        S_EXEC: begin
          if (is_branch) begin
            pc_we  = 1'b1;
            pc_sel = br_taken_i;
            retire = 1'b1;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          if (mem.dmem_ready_i && is_store) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end
        S_WB: begin
          rd_wren = 1'b1;
          pc_we   = 1'b1;
          pc_sel  = is_jump;
          retire  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      cause    <= 2'd0;
      retired  <= '0;
    end else begin
      if (retire) retired <= retired + CNT_W'(1);
      case (state)
        S_FETCH: begin
          if (!en_i) begin
            wait_cnt <= '0;
          end else if (mem.imem_ready_i) begin
            state <= S_DECODE;
          end else if (wait_tc) begin
            state <= S_TRAP;
            cause <= CAUSE_IMEM_TO;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          wait_cnt <= '0;
          if (is_legal) begin
            state <= S_EXEC;
          end else begin
            state <= S_TRAP;
            cause <= CAUSE_ILLEGAL;
          end
        end
        S_EXEC: begin
          wait_cnt <= '0;
          if (is_load || is_store) state <= S_MEM;
          else if (is_branch)      state <= S_FETCH;
          else                     state <= S_WB;
        end
        S_MEM: begin
          if (mem.dmem_ready_i) begin
            wait_cnt <= '0;
            state    <= is_store ? S_FETCH : S_WB;
          end else if (wait_tc) begin
            state <= S_TRAP;
            cause <= CAUSE_DMEM_TO;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_WB: begin
          wait_cnt <= '0;
          state    <= S_FETCH;
        end
        S_TRAP: state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign mem.imem_req_o = imem_req;
  assign mem.dmem_req_o = dmem_req;
  assign mem.dmem_we_o  = dmem_we;
  assign ir_we_o        = ir_we;
  assign pc_we_o        = pc_we;
  assign pc_sel_o       = pc_sel;
  assign rd_wren_o      = rd_wren;
  assign trap_o         = (state == S_TRAP);
  assign trap_cause_o   = cause;
  assign state_o        = state;
  assign retired_o      = retired;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: per-cycle expected state/outputs are queued
// as stimulus is driven and compared by a negedge monitor.
module tb_mc_sequencer;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_BRANCH = 7'b1100011, OP_IMM = 7'b0010011,
                         OP_REG = 7'b0110011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111;

  // Output vector bits: {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rd_wren, trap}
  localparam logic [7:0] O_IREQ = 8'h80, O_DREQ = 8'h40, O_DWE = 8'h20, O_IRWE = 8'h10,
                         O_PCWE = 8'h08, O_PCSEL = 8'h04, O_RDWR = 8'h02, O_TRAP = 8'h01;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [6:0]       opcode;
  logic             br_taken;
  logic             ir_we, pc_we, pc_sel, rd_wren, trap;
  logic [1:0]       trap_cause;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;
  logic [7:0]       outs;

  mc_sequencer_if mif();

  mc_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .opcode_i     (opcode),
    .br_taken_i   (br_taken),
    .mem          (mif),
    .ir_we_o      (ir_we),
    .pc_we_o      (pc_we),
    .pc_sel_o     (pc_sel),
    .rd_wren_o    (rd_wren),
    .trap_o       (trap),
    .trap_cause_o (trap_cause),
    .state_o      (state),
    .retired_o    (retired)
  );

  always #5 clk = ~clk;

  assign outs = {mif.imem_req_o, mif.dmem_req_o, mif.dmem_we_o, ir_we, pc_we, pc_sel, rd_wren, trap};

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] o;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               checks = 0;
  int               failures = 0;
  logic [CNT_W-1:0] exp_ret = '0;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({state, outs} !== {mon_e.st, mon_e.o}) begin
        failures++;
        $display("FAIL seq_cycle t=%0t state=%0d outs=%b expected state=%0d outs=%b",
                 $time, state, outs, mon_e.st, mon_e.o);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of handshake inputs and queue what the DUT must show in it.
  task automatic cycle(input bit ir, input bit dr, input logic [2:0] st, input logic [7:0] o);
    mif.imem_ready_i = ir;
    mif.dmem_ready_i = dr;
    exp_q.push_back({st, o});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mif.imem_ready_i = 1'b0;
    mif.dmem_ready_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ret = '0;
  endtask

  task automatic run_instr(input logic [6:0] op, input bit br, input int iwait, input int dwait);
    bit ld, stq, bq, jmp;
    ld  = (op == OP_LOAD);
    stq = (op == OP_STORE);
    bq  = (op == OP_BRANCH);
    jmp = (op == OP_JAL) || (op == OP_JALR);
    opcode   = op;
    br_taken = br;
    en       = 1'b1;
    for (int i = 0; i < iwait; i++) cycle(1'b0, 1'b0, S_FETCH, O_IREQ);
    cycle(1'b1, 1'b0, S_FETCH, O_IREQ | O_IRWE);
    cycle(1'b0, 1'b0, S_DECODE, 8'h00);
    cycle(1'b0, 1'b0, S_EXEC, bq ? (O_PCWE | (br ? O_PCSEL : 8'h00)) : 8'h00);
    if (ld || stq) begin
      for (int i = 0; i < dwait; i++) cycle(1'b0, 1'b0, S_MEM, O_DREQ | (stq ? O_DWE : 8'h00));
      cycle(1'b0, 1'b1, S_MEM, O_DREQ | (stq ? (O_DWE | O_PCWE) : 8'h00));
    end
    if (!bq && !stq) cycle(1'b0, 1'b0, S_WB, O_RDWR | O_PCWE | (jmp ? O_PCSEL : 8'h00));
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    opcode = OP_IMM;
    br_taken = 1'b0;
    mif.imem_ready_i = 1'b1;
    mif.dmem_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (outs[7:1] !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b expected=0000000", outs[7:1]);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({state, retired, trap_cause, trap} !== {S_FETCH, 4'd0, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state state=%0d retired=%0d cause=%0d trap=%b expected 0/0/0/0",
               state, retired, trap_cause, trap);
    end
    rst = 1'b0;
    exp_ret = '0;
  endtask

  task automatic test_idle();
    en = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, S_FETCH, 8'h00);
  endtask

  task automatic test_addi();
    run_instr(OP_IMM, 1'b0, 0, 0);
    checks++;
    if (retired !== exp_ret) begin
      failures++;
      $display("FAIL addi_retired got=%0d expected=%0d", retired, exp_ret);
    end
  endtask

  task automatic test_classes();
    logic [6:0] ops[11] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_REG, OP_STORE,
                            OP_LOAD, OP_BRANCH, OP_BRANCH, OP_STORE, OP_IMM};
    bit         brs[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int         iws[11] = '{0, 1, 0, 2, 0, 0, 0, 0, 1, 0, 3};
    int         dws[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0};
    for (int k = 0; k < 11; k++) begin
      run_instr(ops[k], brs[k], iws[k], dws[k]);
      checks++;
      if (retired !== exp_ret) begin
        failures++;
        $display("FAIL class_retired idx=%0d got=%0d expected=%0d", k, retired, exp_ret);
      end
    end
  endtask

  task automatic test_lw_wait();
    run_instr(OP_LOAD, 1'b0, 0, 3);
    checks++;
    if (state !== S_FETCH || retired !== exp_ret) begin
      failures++;
      $display("FAIL lw_wait state=%0d retired=%0d expected state=0 retired=%0d",
               state, retired, exp_ret);
    end
  endtask

  task automatic test_ready_at_limit();
    run_instr(OP_IMM, 1'b0, TIMEOUT - 1, 0);
    run_instr(OP_LOAD, 1'b0, 0, TIMEOUT - 1);
    run_instr(OP_STORE, 1'b0, TIMEOUT - 1, TIMEOUT - 1);
    checks++;
    if (trap !== 1'b0 || trap_cause !== 2'd0 || retired !== exp_ret) begin
      failures++;
      $display("FAIL ready_at_limit trap=%b cause=%0d retired=%0d expected 0/0/%0d",
               trap, trap_cause, retired, exp_ret);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 17; k++) run_instr(OP_IMM, 1'b0, 0, 0);
    checks++;
    if (retired !== exp_ret || retired !== 4'd1) begin
      failures++;
      $display("FAIL retired_wrap got=%0d expected=%0d", retired, exp_ret);
    end
  endtask

  task automatic test_rst_mid_mem();
    opcode = OP_LOAD;
    en = 1'b1;
    cycle(1'b1, 1'b0, S_FETCH, O_IREQ | O_IRWE);
    cycle(1'b0, 1'b0, S_DECODE, 8'h00);
    cycle(1'b0, 1'b0, S_EXEC, 8'h00);
    cycle(1'b0, 1'b0, S_MEM, O_DREQ);
    cycle(1'b0, 1'b0, S_MEM, O_DREQ);
    do_reset();
    checks++;
    if (state !== S_FETCH || retired !== 4'd0) begin
      failures++;
      $display("FAIL rst_mid_mem state=%0d retired=%0d expected 0/0", state, retired);
    end
  endtask

  task automatic test_illegal();
    opcode = 7'b0000000;
    en = 1'b1;
    cycle(1'b1, 1'b0, S_FETCH, O_IREQ | O_IRWE);
    cycle(1'b0, 1'b0, S_DECODE, 8'h00);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, S_TRAP, O_TRAP);
    checks++;
    if (trap_cause !== 2'd1) begin
      failures++;
      $display("FAIL illegal_cause got=%0d expected=1", trap_cause);
    end
    do_reset();
    checks++;
    if (state !== S_FETCH || trap !== 1'b0 || trap_cause !== 2'd0) begin
      failures++;
      $display("FAIL trap_exit state=%0d trap=%b cause=%0d expected 0/0/0", state, trap, trap_cause);
    end
  endtask

  task automatic test_imem_timeout();
    opcode = OP_IMM;
    en = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) cycle(1'b0, 1'b0, S_FETCH, O_IREQ);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, S_TRAP, O_TRAP);
    checks++;
    if (trap_cause !== 2'd2) begin
      failures++;
      $display("FAIL imem_timeout_cause got=%0d expected=2", trap_cause);
    end
    do_reset();
  endtask

  task automatic test_dmem_timeout();
    opcode = OP_LOAD;
    en = 1'b1;
    cycle(1'b1, 1'b0, S_FETCH, O_IREQ | O_IRWE);
    cycle(1'b0, 1'b0, S_DECODE, 8'h00);
    cycle(1'b0, 1'b0, S_EXEC, 8'h00);
    for (int i = 0; i < TIMEOUT; i++) cycle(1'b0, 1'b0, S_MEM, O_DREQ);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, S_TRAP, O_TRAP);
    checks++;
    if (trap_cause !== 2'd3 || retired !== 4'd0) begin
      failures++;
      $display("FAIL dmem_timeout got cause=%0d retired=%0d expected 3/0", trap_cause, retired);
    end
    do_reset();
  endtask

  initial begin
    mif.imem_ready_i = 1'b0;
    mif.dmem_ready_i = 1'b0;
    test_reset();
    test_idle();
    test_addi();
    test_classes();
    test_lw_wait();
    test_ready_at_limit();
    test_back_to_back();
    test_rst_mid_mem();
    test_illegal();
    test_imem_timeout();
    test_dmem_timeout();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk_i.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum wait cycles per memory handshake; a value of 0 SHALL disable the timeout.
REQ-003 Parameter CNT_W, default 32, SHALL set the width of the retired-instruction counter.
REQ-004 Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- en_i  in  1  run enable, sampled only in FETCH
- opcode_i  in  7  opcode field of the latched instruction register
- br_taken_i  in  1  branch-compare result for the current instruction
- imem_ready_i  in  1  instruction memory data valid
- dmem_ready_i  in  1  data memory access complete
- imem_req_o  out  1  instruction fetch request
- dmem_req_o  out  1  data memory request
- dmem_we_o  out  1  data memory write (store)
- ir_we_o  out  1  latch the instruction register
- pc_we_o  out  1  update the PC
- pc_sel_o  out  1  0 = PC+4, 1 = ALU result
- rd_wren_o  out  1  register file write enable
- trap_o  out  1  sticky fault flag
- trap_cause_o  out  2  0 = none, 1 = illegal opcode, 2 = imem timeout, 3 = dmem timeout
- state_o  out  3  current state encoding
- retired_o  out  CNT_W  retired-instruction count

Function
REQ-005 States SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5, and state_o SHALL equal the current state.
REQ-006 FETCH: when en_i=0, no outputs SHALL be asserted and the state SHALL hold; when en_i=1, imem_req_o SHALL be 1, and when imem_ready_i=1, ir_we_o SHALL be 1 in the same cycle and the next state SHALL be DECODE.
REQ-007 DECODE: this one-cycle state SHALL go to TRAP with cause 1 if opcode_i is not one of 0000011, 0100011, 1100011, 0010011, 0110011, 0110111, 0010111, 1101111 or 1100111; otherwise it SHALL go to EXEC.
REQ-008 EXEC: loads (0000011) and stores (0100011) SHALL go to MEM; a branch (1100011) SHALL assert pc_we_o=1 with pc_sel_o=br_taken_i, retire, and go to FETCH; all other legal opcodes SHALL go to WB.
REQ-009 MEM: dmem_req_o SHALL be 1, and dmem_we_o SHALL be 1 only for stores.
REQ-010 MEM on dmem_ready_i=1: a store SHALL assert pc_we_o=1 with pc_sel_o=0, retire, and go to FETCH; a load SHALL go to WB.
REQ-011 WB: rd_wren_o and pc_we_o SHALL be 1 and the instruction SHALL retire; pc_sel_o SHALL be 1 for JAL/JALR and 0 otherwise; the next state SHALL be FETCH.
REQ-012 Each state SHALL be a single clock cycle, except FETCH and MEM, which SHALL last until the ready handshake completes.
REQ-013 Minimum latency per instruction class, with ready held at 1:
- ALU/LUI/AUIPC/JAL/JALR: 4 cycles
- branch: 3 cycles
- store: 4 cycles
- load: 5 cycles
REQ-014 A wait counter SHALL be cleared on entry to FETCH (with en_i=1) and on entry to MEM, and SHALL increment each cycle in which ready is 0.
REQ-015 If TIMEOUT is nonzero and the wait counter reaches TIMEOUT with ready still 0, the next state SHALL be TRAP, with cause 2 from FETCH or cause 3 from MEM.
REQ-016 If ready is 1 in the same cycle the wait counter reaches TIMEOUT, the handshake SHALL complete normally and no trap SHALL occur.
REQ-017 TRAP SHALL be absorbing: trap_o=1, trap_cause_o SHALL hold, all request and enable outputs SHALL be 0, and only rst_i SHALL leave it.
REQ-018 Retiring an instruction SHALL increment retired_o by 1, and retired_o SHALL wrap modulo 2^CNT_W.
REQ-019 Control outputs SHALL be combinational functions of the state and inputs; state, wait counter, trap cause and retired_o SHALL be registered.

Reset
REQ-020 When rst_i=1 at a rising edge, the state SHALL become FETCH and retired_o, the wait counter, trap_o and trap_cause_o SHALL become 0, regardless of the current state, including mid-handshake and TRAP.
REQ-021 While in reset, imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o and rd_wren_o SHALL be 0.

Verification
REQ-022 ADDI (0010011), both ready signals tied to 1 -> states 0,1,2,4; rd_wren_o=1 and pc_we_o=1 in WB with pc_sel_o=0; retired_o goes from 0 to 1.
REQ-023 LW, with dmem_ready_i low for 3 cycles -> MEM lasts 4 cycles and dmem_we_o=0; WB follows; total latency is 8 cycles.
REQ-024 BEQ with br_taken_i=1 -> pc_we_o=1 and pc_sel_o=1 in EXEC; no WB; returns to FETCH after 3 cycles.
REQ-025 opcode_i=0000000 -> TRAP in the cycle after DECODE with trap_cause_o=1; all enables stay 0 for 20 cycles; rst_i=1 then returns to FETCH with trap_o=0.
REQ-026 With TIMEOUT=16 and imem_ready_i held 0 -> TRAP with cause 2 after 16 wait cycles; with ready=1 on the 16th cycle -> DECODE and no trap.
REQ-027 With CNT_W=4, retire 17 ADDIs -> retired_o=1 (wraps); rst_i asserted mid-MEM -> state 0 and retired_o=0.
